// File: rtl/rca_config_unit_if.sv
// Handshake bundle between the issue stage, the RCA dispatch unit and the
// accelerator config/execute/illegal channels.
interface rca_config_unit_if #(
    parameter int SEL_W = 1,
    parameter int ID_W  = 3
);
    logic              issue_valid;
    logic              issue_ready;
    logic [31:0]       issue_instruction;
    logic [31:0]       issue_rs1;
    logic [31:0]       issue_rs2;
    logic [ID_W-1:0]   issue_id;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [SEL_W-1:0]  cfg_rca_sel;
    logic [2:0]        cfg_type;
    logic [31:0]       cfg_addr;
    logic [31:0]       cfg_data;

    logic              use_valid;
    logic              use_ready;
    logic [SEL_W-1:0]  use_rca_sel;
    logic [31:0]       use_rs1;
    logic [31:0]       use_rs2;
    logic [ID_W-1:0]   use_id;

    logic              illegal_valid;
    logic [ID_W-1:0]   illegal_id;

    // Dispatch unit side: consumes issue, produces accelerator requests.
    modport slave (
        input  issue_valid, issue_instruction, issue_rs1, issue_rs2, issue_id,
        output issue_ready,
        output cfg_valid, cfg_rca_sel, cfg_type, cfg_addr, cfg_data,
        input  cfg_ready,
        output use_valid, use_rca_sel, use_rs1, use_rs2, use_id,
        input  use_ready,
        output illegal_valid, illegal_id
    );

    // Issue/accelerator side.
    modport master (
        output issue_valid, issue_instruction, issue_rs1, issue_rs2, issue_id,
        input  issue_ready,
        input  cfg_valid, cfg_rca_sel, cfg_type, cfg_addr, cfg_data,
        output cfg_ready,
        input  use_valid, use_rca_sel, use_rs1, use_rs2, use_id,
        output use_ready,
        input  illegal_valid, illegal_id
    );
endinterface

// File: rtl/rca_config_unit.sv
// RCA dispatch stage: buffers RCA-opcode instructions in an in-order FIFO,
// decodes the head and sends it on the config or execute channel, or flags
// it as illegal. At most one request is outstanding at any time.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | no request outstanding; decode FIFO head when visible
//   ST_CFG   | cfg_valid high, waiting for cfg_ready, then pop
//   ST_USE   | use_valid high, waiting for use_ready, then pop
module rca_config_unit #(
    parameter int NUM_RCAS   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 3,
    localparam int SEL_W     = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    rca_config_unit_if.slave bus,
    output logic             idle
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_USE} state_t;

    logic [31:0]     instr_mem_q [FIFO_DEPTH];
    logic [31:0]     rs1_mem_q   [FIFO_DEPTH];
    logic [31:0]     rs2_mem_q   [FIFO_DEPTH];
    logic [ID_W-1:0] id_mem_q    [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    // Write pointer as seen by the read side; a new entry becomes decodable
    // one cycle after it is written.
    logic [PTR_W-1:0] wr_vis_q;

    state_t           state_q, state_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic [SEL_W-1:0] cfg_sel_q, cfg_sel_d;
    logic [2:0]       cfg_type_q, cfg_type_d;
    logic [31:0]      cfg_addr_q, cfg_addr_d;
    logic [31:0]      cfg_data_q, cfg_data_d;
    logic             use_valid_q, use_valid_d;
    logic [SEL_W-1:0] use_sel_q, use_sel_d;
    logic [31:0]      use_rs1_q, use_rs1_d;
    logic [31:0]      use_rs2_q, use_rs2_d;
    logic [ID_W-1:0]  use_id_q, use_id_d;
    logic             illegal_valid_q, illegal_valid_d;
    logic [ID_W-1:0]  illegal_id_q, illegal_id_d;

    logic full, empty, head_avail, push, pop;

    logic [31:0]      head_instr, head_rs1, head_rs2;
    logic [ID_W-1:0]  head_id;
    logic [6:0]       head_opcode, head_fn7;
    logic [2:0]       head_fn3;
    logic [5:0]       fn7_hi;
    logic [SEL_W-1:0] head_sel;
    logic             sel_ok, head_legal;
    logic             unused_fields;

    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign head_avail = (wr_vis_q != rd_ptr_q);
    assign push       = bus.issue_valid && !full;

    assign head_instr  = instr_mem_q[rd_ptr_q[AW-1:0]];
    assign head_rs1    = rs1_mem_q[rd_ptr_q[AW-1:0]];
    assign head_rs2    = rs2_mem_q[rd_ptr_q[AW-1:0]];
    assign head_id     = id_mem_q[rd_ptr_q[AW-1:0]];
    assign head_opcode = head_instr[6:0];
    assign head_fn3    = head_instr[14:12];
    assign head_fn7    = head_instr[31:25];
    assign fn7_hi      = head_fn7[5:0] >> SEL_W;
    assign head_sel    = head_fn7[SEL_W-1:0];
    assign sel_ok      = (32'(head_sel) < 32'(NUM_RCAS));
    assign head_legal  = (head_opcode == 7'b0101011) && head_fn7[6] &&
                         (fn7_hi == 6'd0) && sel_ok && (head_fn3 <= 3'b100);
    // Register/rd fields of the instruction word are not used by dispatch.
    assign unused_fields = ^{head_instr[24:15], head_instr[11:7]};

    // Instruction buffer storage; contents need no reset, pointers guard them.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q[AW-1:0]] <= bus.issue_instruction;
            rs1_mem_q[wr_ptr_q[AW-1:0]]   <= bus.issue_rs1;
            rs2_mem_q[wr_ptr_q[AW-1:0]]   <= bus.issue_rs2;
            id_mem_q[wr_ptr_q[AW-1:0]]    <= bus.issue_id;
        end
    end

    // Next-state for the dispatch FSM, its registered outputs and the pointers.
    always_comb begin
        state_d         = state_q;
        cfg_valid_d     = cfg_valid_q;
        cfg_sel_d       = cfg_sel_q;
        cfg_type_d      = cfg_type_q;
        cfg_addr_d      = cfg_addr_q;
        cfg_data_d      = cfg_data_q;
        use_valid_d     = use_valid_q;
        use_sel_d       = use_sel_q;
        use_rs1_d       = use_rs1_q;
        use_rs2_d       = use_rs2_q;
        use_id_d        = use_id_q;
        illegal_valid_d = 1'b0;
        illegal_id_d    = illegal_id_q;
        pop             = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The cycle after an illegal pop is a bubble so illegal
                // entries drain at the same rate as real handshakes.
                if (head_avail && !illegal_valid_q) begin
                    if (!head_legal) begin
                        illegal_valid_d = 1'b1;
                        illegal_id_d    = head_id;
                        pop             = 1'b1;
                    end else if (head_fn3 == 3'b000) begin
                        use_valid_d = 1'b1;
                        use_sel_d   = head_sel;
                        use_rs1_d   = head_rs1;
                        use_rs2_d   = head_rs2;
                        use_id_d    = head_id;
                        state_d     = ST_USE;
                    end else begin
                        cfg_valid_d = 1'b1;
                        cfg_sel_d   = head_sel;
                        cfg_type_d  = head_fn3;
                        cfg_addr_d  = head_rs2;
                        cfg_data_d  = head_rs1;
                        state_d     = ST_CFG;
                    end
                end
            end
            ST_CFG: begin
                if (bus.cfg_ready) begin
                    cfg_valid_d = 1'b0;
                    pop         = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_USE: begin
                if (bus.use_ready) begin
                    use_valid_d = 1'b0;
                    pop         = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    // All control state with synchronous reset; reset drops any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            wr_vis_q        <= '0;
            cfg_valid_q     <= 1'b0;
            cfg_sel_q       <= '0;
            cfg_type_q      <= '0;
            cfg_addr_q      <= '0;
            cfg_data_q      <= '0;
            use_valid_q     <= 1'b0;
            use_sel_q       <= '0;
            use_rs1_q       <= '0;
            use_rs2_q       <= '0;
            use_id_q        <= '0;
            illegal_valid_q <= 1'b0;
            illegal_id_q    <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_vis_q        <= wr_ptr_q;
            cfg_valid_q     <= cfg_valid_d;
            cfg_sel_q       <= cfg_sel_d;
            cfg_type_q      <= cfg_type_d;
            cfg_addr_q      <= cfg_addr_d;
            cfg_data_q      <= cfg_data_d;
            use_valid_q     <= use_valid_d;
            use_sel_q       <= use_sel_d;
            use_rs1_q       <= use_rs1_d;
            use_rs2_q       <= use_rs2_d;
            use_id_q        <= use_id_d;
            illegal_valid_q <= illegal_valid_d;
            illegal_id_q    <= illegal_id_d;
        end
    end

    assign bus.issue_ready   = !full;
    assign bus.cfg_valid     = cfg_valid_q;
    assign bus.cfg_rca_sel   = cfg_sel_q;
    assign bus.cfg_type      = cfg_type_q;
    assign bus.cfg_addr      = cfg_addr_q;
    assign bus.cfg_data      = cfg_data_q;
    assign bus.use_valid     = use_valid_q;
    assign bus.use_rca_sel   = use_sel_q;
    assign bus.use_rs1       = use_rs1_q;
    assign bus.use_rs2       = use_rs2_q;
    assign bus.use_id        = use_id_q;
    assign bus.illegal_valid = illegal_valid_q;
    assign bus.illegal_id    = illegal_id_q;
    assign idle              = empty && (state_q == ST_IDLE);

endmodule
